// File: rtl/mem_port_bridge_pkg.sv
// Shared encodings for the per-channel memory port bridge.
// Optional watchdog feature is controlled by macro MEM_BRIDGE_TIMEOUT_EN.
package mem_port_bridge_pkg;

  localparam logic [1:0] RW_IDLE  = 2'd0;
  localparam logic [1:0] RW_READ  = 2'd1;
  localparam logic [1:0] RW_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Controller command for a captured core request.
  function automatic logic [1:0] rw_cmd(input logic we);
    return we ? RW_WRITE : RW_READ;
  endfunction

endpackage

// File: rtl/mem_port_chan.sv
// One independent bridge channel: request/ack FSM with registered command outputs.
// With MEM_BRIDGE_TIMEOUT_EN defined, a watchdog aborts a WAIT lasting TIMEOUT cycles.
module mem_port_chan
  import mem_port_bridge_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req,
  input  logic            we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW/8-1:0] sel,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata,
  output logic            ack,
  output logic            err,
  output logic [1:0]      rw_flag,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   write_data,
  output logic [DW/8-1:0] write_mask,
  input  logic [DW-1:0]   read_data,
  input  logic            busy,
  input  logic            done
);

  state_t          state_r;
  logic [1:0]      rw_flag_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   write_data_r;
  logic [DW/8-1:0] write_mask_r;
  logic [DW-1:0]   rdata_r;
  logic            ack_r;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_r;
  logic          err_r;
`endif

  // Channel FSM, command registers, read-data holding register and watchdog.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= ST_IDLE;
      rw_flag_r    <= RW_IDLE;
      addr_r       <= {AW{1'b0}};
      write_data_r <= {DW{1'b0}};
      write_mask_r <= {(DW/8){1'b0}};
      rdata_r      <= {DW{1'b0}};
      ack_r        <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_r        <= {CW{1'b0}};
      err_r        <= 1'b0;
`endif
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req && !busy) begin
            rw_flag_r    <= rw_cmd(we);
            addr_r       <= req_addr;
            write_data_r <= we ? wdata : {DW{1'b0}};
            write_mask_r <= we ? sel : {(DW/8){1'b0}};
            state_r      <= ST_WAIT;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            cnt_r        <= {CW{1'b0}};
`endif
          end
        end
        ST_WAIT: begin
          // done beats the watchdog when both land in the same cycle
          if (done) begin
            if (rw_flag_r == RW_READ) begin
              rdata_r <= read_data;
            end
            rw_flag_r    <= RW_IDLE;
            addr_r       <= {AW{1'b0}};
            write_data_r <= {DW{1'b0}};
            write_mask_r <= {(DW/8){1'b0}};
            ack_r        <= 1'b1;
            state_r      <= ST_RESP;
`ifdef MEM_BRIDGE_TIMEOUT_EN
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            rw_flag_r    <= RW_IDLE;
            addr_r       <= {AW{1'b0}};
            write_data_r <= {DW{1'b0}};
            write_mask_r <= {(DW/8){1'b0}};
            ack_r        <= 1'b1;
            err_r        <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
`endif
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
`ifdef MEM_BRIDGE_TIMEOUT_EN
          err_r   <= 1'b0;
`endif
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rw_flag    = rw_flag_r;
  assign addr       = addr_r;
  assign write_data = write_data_r;
  assign write_mask = write_mask_r;
  assign rdata      = rdata_r;
  assign ack        = ack_r;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  assign err        = err_r;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: rtl/mem_port_bridge.sv
// NCH-channel bridge between core memory ports and the memory controller; bus slicing only.
// Watchdog per channel is enabled by defining MEM_BRIDGE_TIMEOUT_EN.
module mem_port_bridge
  import mem_port_bridge_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NCH-1:0]      req_i,
  input  logic [NCH-1:0]      we_i,
  input  logic [NCH*AW-1:0]   addr_i,
  input  logic [NCH*DW/8-1:0] sel_i,
  input  logic [NCH*DW-1:0]   wdata_i,
  output logic [NCH*DW-1:0]   rdata_o,
  output logic [NCH-1:0]      ack_o,
  output logic [NCH-1:0]      err_o,
  output logic [2*NCH-1:0]    rw_flag,
  output logic [NCH*AW-1:0]   addr,
  output logic [NCH*DW-1:0]   write_data,
  output logic [NCH*DW/8-1:0] write_mask,
  input  logic [NCH*DW-1:0]   read_data,
  input  logic [NCH-1:0]      busy,
  input  logic [NCH-1:0]      done
);

  localparam int BW = DW / 8;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    mem_port_chan #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .CLK        (CLK),
      .RST        (RST),
      .req        (req_i[i]),
      .we         (we_i[i]),
      .req_addr   (addr_i[i*AW +: AW]),
      .sel        (sel_i[i*BW +: BW]),
      .wdata      (wdata_i[i*DW +: DW]),
      .rdata      (rdata_o[i*DW +: DW]),
      .ack        (ack_o[i]),
      .err        (err_o[i]),
      .rw_flag    (rw_flag[2*i +: 2]),
      .addr       (addr[i*AW +: AW]),
      .write_data (write_data[i*DW +: DW]),
      .write_mask (write_mask[i*BW +: BW]),
      .read_data  (read_data[i*DW +: DW]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule

// File: doc/mem_port_bridge.md
# mem_port_bridge

- Parametrised bridge between the CPU core's per-channel memory ports (instruction fetch, data load/store, …) and the multi-channel memory controller.
- Replaces the fixed two-channel, partly combinational glue with NCH independent registered channels, each running a request/acknowledge handshake.
- Each channel holds its read data until the next transaction completes; an optional watchdog can abort a stalled transaction.
- Sits between `openrisc` and the memory controller inside the core wrapper.

## Interface
Parameters:
- NCH, 2: number of independent channels; channel 0 is the lowest slice of every packed bus.
- AW, 32: address width per channel.
- DW, 32: data width per channel; multiple of 8.
- TIMEOUT, 1024: watchdog limit in cycles; used only with MEM_BRIDGE_TIMEOUT_EN.

Ports:
- CLK  in  1  sole clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- req_i  in  NCH  per-channel request (core `ce`); held until ack_o.
- we_i  in  NCH  1 = write, 0 = read.
- addr_i  in  NCH*AW  request addresses.
- sel_i  in  NCH*DW/8  byte enables for writes.
- wdata_i  in  NCH*DW  write data.
- rdata_o  out  NCH*DW  last read data per channel.
- ack_o  out  NCH  one-cycle completion pulse.
- err_o  out  NCH  qualifies ack_o: transaction timed out.
- rw_flag  out  2*NCH  controller command per channel: 0 idle, 1 read, 2 write.
- addr  out  NCH*AW  controller address.
- write_data  out  NCH*DW  controller write data.
- write_mask  out  NCH*DW/8  controller byte mask; all zero for reads.
- read_data  in  NCH*DW  controller read data; valid in the done cycle.
- busy  in  NCH  controller cannot accept a new command on this channel.
- done  in  NCH  one-cycle completion from the controller.

## Operation
- Each channel has its own FSM with states IDLE, WAIT and RESP. Channels never interact and have no priority.
- **IDLE**
  - On req_i=1 and busy=0, capture we/addr/sel/wdata into the output registers.
  - Drive rw_flag=1 for a read or 2 for a write, and go to WAIT.
  - Read: write_mask=0 and write_data=0.
  - If req_i=1 and busy=1, stay in IDLE.
- **WAIT**
  - Command outputs are held stable.
  - When done=1: set rw_flag, addr, write_mask and write_data to 0.
  - For a read, latch read_data slice into rdata_o. Then go to RESP.
- **RESP**
  - ack_o=1 for exactly one cycle; req_i is ignored in this state. Then go to IDLE.
- rdata_o keeps its value across writes, timeouts and idle periods; it changes only when a read completes.
- done received in IDLE or RESP is ignored. This covers stray done pulses and done for a command aborted by reset.
- Reset, whether at power-up or mid-transaction:
  - every FSM returns to IDLE;
  - rw_flag, addr, write_data, write_mask, rdata_o, ack_o and err_o all go to 0;
  - no ack_o is produced for the aborted transaction.

## Timing
- req_i sampled high at edge 0 → rw_flag visible after edge 0.
- done high in cycle k → ack_o high in cycle k+1, with rdata_o already valid in that cycle.
- Minimum request-to-ack: 2 cycles (done in the first command cycle).
- Back-to-back: the core may hold req_i with new operands through the ack cycle. The next capture happens in IDLE one cycle after ack, so the per-channel issue rate is 1 transaction per 3 cycles plus controller latency.
- All outputs are registered; there are no combinational paths from input to output.
- Simultaneous done on several channels → their ack_o pulses occur in the same cycle.

## Configuration
- **MEM_BRIDGE_TIMEOUT_EN defined:**
  - A per-channel counter, width clog2(TIMEOUT+1), clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no done, the channel drops rw_flag and its companions to 0 and goes to RESP with ack_o=1 and err_o=1. rdata_o is unchanged.
  - done arriving in the same cycle as the limit wins: normal completion, err_o=0.
- **MEM_BRIDGE_TIMEOUT_EN undefined:**
  - No counter; WAIT persists until done.
  - err_o is tied to 0, and the port is still present.

## Structure
- A shared package or defines file holds:
  - rw_flag encodings RW_IDLE=2'd0, RW_READ=2'd1, RW_WRITE=2'd2;
  - FSM state encodings ST_IDLE, ST_WAIT, ST_RESP.
- Sub-module `mem_port_chan` contains one channel (FSM, operand registers, optional watchdog). The top level instantiates NCH copies in a generate loop and does only bus slicing.

## Test plan
- **Single read, ch0:** addr 0x100, done 3 cycles after rw_flag=1 with read_data 0xDEADBEEF → ack_o[0] 1 cycle later, rdata_o=0xDEADBEEF, write_mask=0.
- **Write, ch1:** addr 0x40, sel 4'b0011, wdata 0x1234 → rw_flag=2, write_mask=0x3 until done; ack follows; rdata_o[1] unchanged.
- **Busy gating:** req_i with busy=1 for 5 cycles → rw_flag stays 0; issues the cycle after busy falls.
- **Concurrency:** NCH=2, both channels get done in the same cycle → both ack_o pulse together with correct data per slice. A stray done in IDLE → no ack.
- **Reset mid-WAIT:** assert RST=0 → all outputs 0 immediately; a done after release produces no ack.
- **Timeout (macro on, TIMEOUT=8):** no done → ack_o=1, err_o=1 exactly 8 cycles into WAIT. done in cycle 8 → err_o=0.
